// File: rtl/sd_cmd_tx_ctrl.sv
// SD command-path transmit sequencer.
// Drives the upstream 40-bit MSb-first shift register with load and shift strobes.
// Folds the looped-back serial bit into a CRC7, then appends the CRC7 and the end bit.
// Optional feature macro SD_CMD_TX_NCC_EN: after the end bit, the CMD line is released
// for NccBits bit periods before the block returns to idle.
module sd_cmd_tx_ctrl #(
  parameter int unsigned BodyBits = 40,
  parameter int unsigned NccBits  = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                bit_tick_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [5:0]          cmd_index_i,
  input  logic [31:0]         cmd_arg_i,
  output logic [BodyBits-1:0] par_data_o,
  output logic                par_write_en_o,
  output logic                shift_en_o,
  input  logic                ser_bit_i,
  output logic                cmd_o,
  output logic                cmd_oe_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int unsigned CntW = 6;
  localparam int unsigned CrcW = 7;
  localparam logic [CntW-1:0] BodyLast = CntW'(BodyBits - 1);
  localparam logic [CntW-1:0] CrcLast  = CntW'(CrcW - 1);
  localparam logic [CntW-1:0] NccLast  = CntW'(NccBits - 1);
  localparam logic [CrcW-1:0] CrcPoly  = 7'h09;

`ifdef SD_CMD_TX_NCC_EN
  localparam bit NccEn = 1'b1;
`else
  localparam bit NccEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_BODY,
    S_CRC,
    S_END,
    S_NCC
  } state_t;

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CrcW-1:0] crc_q, crc_d;

  // Start bit, transmission bit, index, argument: the frame body handed to the shift register.
  assign par_data_o = BodyBits'({1'b0, 1'b1, cmd_index_i, cmd_arg_i});

  // State, bit counter and CRC registers with synchronous abort to idle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      crc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
    end
  end

  // Next-state, counter/CRC update and line/handshake outputs.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    crc_d          = crc_q;
    cmd_o          = 1'b1;
    cmd_oe_o       = 1'b0;
    cmd_ready_o    = 1'b0;
    busy_o         = 1'b1;
    done_o         = 1'b0;
    par_write_en_o = 1'b0;
    shift_en_o     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        // A tick arriving in the accept cycle is deliberately dropped.
        if (cmd_valid_i) begin
          par_write_en_o = 1'b1;
          crc_d          = '0;
          cnt_d          = '0;
          state_d        = S_BODY;
        end
      end
      S_BODY: begin
        cmd_o      = ser_bit_i;
        cmd_oe_o   = 1'b1;
        shift_en_o = bit_tick_i;
        if (bit_tick_i) begin
          crc_d = {crc_q[CrcW-2:0], 1'b0} ^ ((crc_q[CrcW-1] ^ ser_bit_i) ? CrcPoly : '0);
          if (cnt_q == BodyLast) begin
            cnt_d   = '0;
            state_d = S_CRC;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_CRC: begin
        cmd_o    = crc_q[CrcW-1];
        cmd_oe_o = 1'b1;
        if (bit_tick_i) begin
          crc_d = {crc_q[CrcW-2:0], 1'b0};
          if (cnt_q == CrcLast) begin
            cnt_d   = '0;
            state_d = S_END;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_END: begin
        cmd_oe_o = 1'b1;
        if (bit_tick_i) begin
          cnt_d = '0;
          if (NccEn) begin
            state_d = S_NCC;
          end else begin
            done_o  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_NCC: begin
        // Line released but block still busy; only reachable with the feature enabled.
        if (bit_tick_i) begin
          if (cnt_q == NccLast) begin
            cnt_d   = '0;
            done_o  = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
